// File: rtl/axicb_mst_switch_wr_arb_if.sv
// Write-channel bundle between four master-side switches and one slave port.
// The slave modport is the switch itself; the master modport is its environment.
interface axicb_mst_switch_wr_arb_if #(
  parameter int AXI_ADDR_W = 8,
  parameter int AXI_ID_W   = 8,
  parameter int MST_NB     = 4,
  parameter int AWCH_W     = AXI_ADDR_W,
  parameter int WCH_W      = 8,
  parameter int BCH_W      = AXI_ID_W + 2
);
  logic [MST_NB-1:0]        i_awvalid;
  logic [MST_NB-1:0]        i_awready;
  logic [MST_NB*AWCH_W-1:0] i_awch;
  logic [MST_NB-1:0]        i_wvalid;
  logic [MST_NB-1:0]        i_wready;
  logic [MST_NB-1:0]        i_wlast;
  logic [MST_NB*WCH_W-1:0]  i_wch;
  logic [MST_NB-1:0]        i_bvalid;
  logic [MST_NB-1:0]        i_bready;
  logic [BCH_W-1:0]         i_bch;
  logic                     o_awvalid;
  logic                     o_awready;
  logic [AWCH_W-1:0]        o_awch;
  logic                     o_wvalid;
  logic                     o_wready;
  logic                     o_wlast;
  logic [WCH_W-1:0]         o_wch;
  logic                     o_bvalid;
  logic                     o_bready;
  logic [BCH_W-1:0]         o_bch;

  modport slave (
    input  i_awvalid, i_awch, i_wvalid, i_wlast, i_wch, i_bready,
    input  o_awready, o_wready, o_bvalid, o_bch,
    output i_awready, i_wready, i_bvalid, i_bch,
    output o_awvalid, o_awch, o_wvalid, o_wlast, o_wch, o_bready
  );

  modport master (
    output i_awvalid, i_awch, i_wvalid, i_wlast, i_wch, i_bready,
    output o_awready, o_wready, o_bvalid, o_bch,
    input  i_awready, i_wready, i_bvalid, i_bch,
    input  o_awvalid, o_awch, o_wvalid, o_wlast, o_wch, o_bready
  );
endinterface

// File: rtl/axicb_mst_switch_wr_arb.sv
// Slave-side AXI write switch: round-robin AW arbitration over four masters, W steered
// in AW grant order through a small FIFO, B routed back to the issuing master by ID.
module axicb_mst_switch_wr_arb #(
  parameter int                  AXI_ADDR_W    = 8,
  parameter int                  AXI_ID_W      = 8,
  parameter int                  MST_NB        = 4,
  parameter logic [AXI_ID_W-1:0] MST_ID_SEL    = 8'h30,
  parameter logic [AXI_ID_W-1:0] MST0_ID_MASK  = 8'h00,
  parameter logic [AXI_ID_W-1:0] MST1_ID_MASK  = 8'h10,
  parameter logic [AXI_ID_W-1:0] MST2_ID_MASK  = 8'h20,
  parameter logic [AXI_ID_W-1:0] MST3_ID_MASK  = 8'h30,
  parameter int                  WFIFO_DEPTH_W = 3,
  parameter int                  AWCH_W        = AXI_ADDR_W,
  parameter int                  WCH_W         = 8
) (
  input  logic                        aclk,
  input  logic                        srst,
  axicb_mst_switch_wr_arb_if.slave    bus
);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_BUSY = 1'b1} state_e;

  localparam int MST_W = $clog2(MST_NB);
  localparam int DEPTH = 1 << WFIFO_DEPTH_W;
  localparam logic [WFIFO_DEPTH_W:0] CNT_FULL = (WFIFO_DEPTH_W + 1)'(DEPTH);

  function automatic logic [AXI_ID_W-1:0] mst_mask(input logic [MST_W-1:0] n);
    logic [AXI_ID_W-1:0] m;
    case (n)
      2'd0:    m = MST0_ID_MASK;
      2'd1:    m = MST1_ID_MASK;
      2'd2:    m = MST2_ID_MASK;
      default: m = MST3_ID_MASK;
    endcase
    return m;
  endfunction

  state_e                   state_q, state_d;
  logic [MST_W-1:0]         grant_q, grant_d;
  logic [MST_W-1:0]         rr_ptr_q, rr_ptr_d;
  logic [MST_W-1:0]         fifo_q [DEPTH];
  logic [MST_W-1:0]         fifo_d [DEPTH];
  logic [WFIFO_DEPTH_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [WFIFO_DEPTH_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [WFIFO_DEPTH_W:0]   cnt_q, cnt_d;
  logic                     full_q, full_d;
  logic                     empty_q, empty_d;
  logic                     rst_dly_q, rst_dly_d;

  logic                     block_s;
  logic                     found_s;
  logic [MST_W-1:0]         pick_s, scan_s, head_s, b_sel_s;
  logic                     aw_valid_s, aw_push_s;
  logic [MST_NB-1:0]        aw_ready_s, w_ready_s, b_valid_s;
  logic                     w_valid_s, w_last_s, w_pop_s;
  logic                     b_hit_s, b_ready_s;
  logic [AXI_ID_W-1:0]      b_id_s;

  // Handshake outputs are held low during reset and for the cycle right after it.
  assign block_s = srst | rst_dly_q;
  assign head_s  = fifo_q[rd_ptr_q];
  assign b_id_s  = bus.o_bch[AXI_ID_W-1:0];

  // AW arbiter: pick in IDLE, hold the grant in BUSY until the slave accepts.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    aw_valid_s = 1'b0;
    aw_ready_s = '0;
    aw_push_s  = 1'b0;
    found_s    = 1'b0;
    pick_s     = rr_ptr_q;
    scan_s     = rr_ptr_q;
    case (state_q)
      S_IDLE: begin
        for (int k = 0; k < MST_NB; k++) begin
          scan_s = rr_ptr_q + MST_W'(k);
          if (!found_s && bus.i_awvalid[scan_s]) begin
            found_s = 1'b1;
            pick_s  = scan_s;
          end else begin
            found_s = found_s;
          end
        end
        if (found_s) begin
          grant_d = pick_s;
          state_d = S_BUSY;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        aw_valid_s          = bus.i_awvalid[grant_q] & ~full_q & ~block_s;
        aw_ready_s[grant_q] = bus.o_awready & ~full_q & ~block_s;
        if (aw_valid_s && bus.o_awready) begin
          aw_push_s = 1'b1;
          rr_ptr_d  = grant_q + MST_W'(1);
          state_d   = S_IDLE;
        end else begin
          state_d   = S_BUSY;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // W steering from the FIFO head; the burst retires on its last beat.
  always_comb begin
    w_valid_s = 1'b0;
    w_last_s  = 1'b0;
    w_ready_s = '0;
    w_pop_s   = 1'b0;
    if (!empty_q && !block_s) begin
      w_valid_s         = bus.i_wvalid[head_s];
      w_last_s          = bus.i_wlast[head_s];
      w_ready_s[head_s] = bus.o_wready;
      w_pop_s           = w_valid_s & bus.o_wready & w_last_s;
    end else begin
      w_pop_s           = 1'b0;
    end
  end

  // Grant FIFO bookkeeping; full/empty are registered so AW never sees a same-cycle pop.
  always_comb begin
    fifo_d    = fifo_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    rst_dly_d = srst;
    if (aw_push_s) begin
      fifo_d[wr_ptr_q] = grant_q;
      wr_ptr_d         = wr_ptr_q + WFIFO_DEPTH_W'(1);
    end else begin
      wr_ptr_d         = wr_ptr_q;
    end
    if (w_pop_s) begin
      rd_ptr_d = rd_ptr_q + WFIFO_DEPTH_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({aw_push_s, w_pop_s})
      2'b10:   cnt_d = cnt_q + (WFIFO_DEPTH_W + 1)'(1);
      2'b01:   cnt_d = cnt_q - (WFIFO_DEPTH_W + 1)'(1);
      default: cnt_d = cnt_q;
    endcase
    full_d  = (cnt_d == CNT_FULL);
    empty_d = (cnt_d == '0);
  end

  // B routing by ID; lowest matching master wins, unmatched responses are sunk.
  always_comb begin
    b_hit_s   = 1'b0;
    b_sel_s   = '0;
    b_valid_s = '0;
    b_ready_s = 1'b0;
    for (int n = MST_NB - 1; n >= 0; n--) begin
      if ((b_id_s & MST_ID_SEL) == mst_mask(MST_W'(n))) begin
        b_hit_s = 1'b1;
        b_sel_s = MST_W'(n);
      end else begin
        b_hit_s = b_hit_s;
      end
    end
    if (block_s) begin
      b_ready_s = 1'b0;
    end else if (b_hit_s) begin
      b_valid_s[b_sel_s] = bus.o_bvalid;
      b_ready_s          = bus.i_bready[b_sel_s];
    end else begin
      b_ready_s = 1'b1;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge aclk) begin
    if (srst) begin
      state_q   <= S_IDLE;
      grant_q   <= '0;
      rr_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      rst_dly_q <= 1'b1;
      for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_ptr_q  <= rr_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
      rst_dly_q <= rst_dly_d;
      fifo_q    <= fifo_d;
    end
  end

  assign bus.o_awvalid = aw_valid_s;
  assign bus.i_awready = aw_ready_s;
  assign bus.o_awch    = bus.i_awch[grant_q * AWCH_W +: AWCH_W];
  assign bus.o_wvalid  = w_valid_s;
  assign bus.o_wlast   = w_last_s;
  assign bus.i_wready  = w_ready_s;
  assign bus.o_wch     = bus.i_wch[head_s * WCH_W +: WCH_W];
  assign bus.i_bvalid  = b_valid_s;
  assign bus.o_bready  = b_ready_s;
  assign bus.i_bch     = bus.o_bch;

endmodule

// File: tb/tb_axicb_mst_switch_wr_arb.sv
// Directed bench for axicb_mst_switch_wr_arb: arbitration, W ordering, FIFO full, B routing, reset.
module tb_axicb_mst_switch_wr_arb;
  logic aclk = 1'b0;
  logic srst;
  int   n_cmp = 0;
  int   n_err = 0;

  axicb_mst_switch_wr_arb_if bus ();
  axicb_mst_switch_wr_arb_if bus1 ();

  axicb_mst_switch_wr_arb u_dut (.aclk(aclk), .srst(srst), .bus(bus));

  // Second instance where only master 1 owns an ID pattern.
  axicb_mst_switch_wr_arb #(
    .MST0_ID_MASK(8'h40), .MST1_ID_MASK(8'h10),
    .MST2_ID_MASK(8'h40), .MST3_ID_MASK(8'h40)
  ) u_dut_m1 (.aclk(aclk), .srst(srst), .bus(bus1));

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge aclk);
    #1;
  endtask

  initial begin
    srst = 1'b1;
    bus.i_awvalid = 4'h0;  bus.i_awch = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    bus.i_wvalid  = 4'h0;  bus.i_wlast = 4'h0;  bus.i_wch = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
    bus.i_bready  = 4'hF;  bus.o_awready = 1'b0; bus.o_wready = 1'b0;
    bus.o_bvalid  = 1'b1;  bus.o_bch = 10'h000;
    bus1.i_awvalid = 4'h0; bus1.i_awch = 32'h0; bus1.i_wvalid = 4'h0; bus1.i_wlast = 4'h0;
    bus1.i_wch = 32'h0;    bus1.i_bready = 4'h0; bus1.o_awready = 1'b0; bus1.o_wready = 1'b0;
    bus1.o_bvalid = 1'b0;  bus1.o_bch = 10'h000;

    // Reset: all handshake outputs low, also in the release cycle.
    repeat (3) cyc();
    #2;
    chk("rst_o_awvalid", 32'(bus.o_awvalid), 32'h0);
    chk("rst_i_awready", 32'(bus.i_awready), 32'h0);
    chk("rst_o_wvalid",  32'(bus.o_wvalid),  32'h0);
    chk("rst_i_wready",  32'(bus.i_wready),  32'h0);
    chk("rst_o_bready",  32'(bus.o_bready),  32'h0);
    chk("rst_i_bvalid",  32'(bus.i_bvalid),  32'h0);
    srst = 1'b0;
    #1;
    chk("rel_o_bready", 32'(bus.o_bready), 32'h0);
    chk("rel_i_bvalid", 32'(bus.i_bvalid), 32'h0);
    cyc();
    #2;
    chk("post_o_bready", 32'(bus.o_bready), 32'h1);
    chk("post_i_bvalid", 32'(bus.i_bvalid), 32'h1);
    chk("post_o_awvalid", 32'(bus.o_awvalid), 32'h0);
    bus.o_bvalid = 1'b0; bus.i_bready = 4'h0;

    // Test 1: all four request, grants 0..3 on every other cycle.
    bus.i_awvalid = 4'hF; bus.o_awready = 1'b1;
    #1;
    chk("t1_c0_awvalid", 32'(bus.o_awvalid), 32'h0);
    for (int k = 0; k < 4; k++) begin
      cyc();
      #1;
      chk("t1_grant", 32'(bus.i_awready), 32'(1 << k));
      chk("t1_awch",  32'(bus.o_awch),    32'(8'hA0 + k));
      cyc();
      if (k == 3) bus.i_awvalid = 4'h0;
      #1;
      chk("t1_gap_awvalid", 32'(bus.o_awvalid), 32'h0);
    end
    bus.i_wvalid = 4'hF; bus.i_wlast = 4'hF; bus.o_wready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t1_w_order", 32'(bus.i_wready), 32'(1 << k));
      chk("t1_wch",     32'(bus.o_wch),    32'(8'hD0 + k));
      cyc();
    end
    #1;
    chk("t1_w_empty", 32'(bus.i_wready), 32'h0);
    bus.i_wvalid = 4'h0; bus.i_wlast = 4'h0;

    // Pointer back at 0: M0 beats M3, then M3 follows.
    bus.i_awvalid = 4'b1001;
    cyc();
    #1;
    chk("ptr_first_m0", 32'(bus.i_awready), 32'h1);
    cyc();
    cyc();
    #1;
    chk("ptr_next_m3", 32'(bus.i_awready), 32'h8);
    cyc();
    bus.i_awvalid = 4'h0;
    bus.i_wvalid = 4'hF; bus.i_wlast = 4'hF;
    #1;
    chk("ptr_w0", 32'(bus.i_wready), 32'h1);
    cyc();
    #1;
    chk("ptr_w3", 32'(bus.i_wready), 32'h8);
    cyc();
    #1;
    chk("ptr_wempty", 32'(bus.i_wready), 32'h0);
    bus.i_wvalid = 4'h0; bus.i_wlast = 4'h0;

    // Test 3: AW M1 then M3; M3 drives W early but must wait for M1's burst.
    bus.i_awvalid = 4'b0010; bus.i_wvalid = 4'b1000; bus.i_wlast = 4'b1000;
    #1;
    chk("t3_empty_wready", 32'(bus.i_wready), 32'h0);
    cyc();
    bus.i_awvalid = 4'b1010;
    #1;
    chk("t3_c1_wready", 32'(bus.i_wready), 32'h0);
    cyc();
    bus.i_awvalid = 4'b1000;
    #1;
    chk("t3_head_m1", 32'(bus.i_wready), 32'h2);
    chk("t3_m1_wvalid", 32'(bus.o_wvalid), 32'h0);
    cyc();
    #1;
    chk("t3_m3_aw", 32'(bus.i_awready), 32'h8);
    cyc();
    bus.i_awvalid = 4'h0; bus.i_wvalid = 4'b1010;
    for (int b = 0; b < 4; b++) begin
      if (b == 3) bus.i_wlast = 4'b1010;
      #1;
      chk("t3_beat_wready", 32'(bus.i_wready), 32'h2);
      chk("t3_beat_wvalid", 32'(bus.o_wvalid), 32'h1);
      chk("t3_beat_wlast",  32'(bus.o_wlast),  32'(b == 3));
      chk("t3_beat_wch",    32'(bus.o_wch),    32'hD1);
      cyc();
    end
    #1;
    chk("t3_head_m3", 32'(bus.i_wready), 32'h8);
    chk("t3_m3_wch",  32'(bus.o_wch),    32'hD3);
    cyc();
    #1;
    chk("t3_done", 32'(bus.o_wvalid), 32'h0);
    bus.i_wvalid = 4'h0; bus.i_wlast = 4'h0; bus.o_wready = 1'b0;

    // Test 2: M2 stalled by the slave; grant and payload hold.
    bus.i_awvalid = 4'b0100; bus.o_awready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      cyc();
      if (s == 2) bus.i_awvalid = 4'b0111;
      #1;
      chk("t2_awvalid", 32'(bus.o_awvalid), 32'h1);
      chk("t2_awch",    32'(bus.o_awch),    32'hA2);
      chk("t2_awready", 32'(bus.i_awready), 32'h0);
    end
    bus.o_awready = 1'b1;
    #1;
    chk("t2_accept", 32'(bus.i_awready), 32'h4);
    cyc();
    bus.i_awvalid = 4'h0; bus.i_wvalid = 4'b0100; bus.i_wlast = 4'b0100; bus.o_wready = 1'b1;
    #1;
    chk("t2_w_m2", 32'(bus.i_wready), 32'h4);
    cyc();
    bus.i_wvalid = 4'h0; bus.i_wlast = 4'h0; bus.o_wready = 1'b0;
    #1;
    chk("t2_w_empty", 32'(bus.o_wvalid), 32'h0);

    // Test 4: eight AWs fill the FIFO, the ninth waits for one W pop.
    bus.i_awvalid = 4'hF;
    for (int k = 0; k < 8; k++) begin
      cyc();
      #1;
      chk("t4_fill_grant", 32'(bus.i_awready), 32'(1 << ((3 + k) % 4)));
      cyc();
    end
    cyc();
    #1;
    chk("t4_full_awvalid", 32'(bus.o_awvalid), 32'h0);
    chk("t4_full_awready", 32'(bus.i_awready), 32'h0);
    cyc();
    #1;
    chk("t4_full_hold", 32'(bus.o_awvalid), 32'h0);
    bus.i_wvalid = 4'b1000; bus.i_wlast = 4'b1000; bus.o_wready = 1'b1;
    #1;
    chk("t4_pop_head", 32'(bus.i_wready), 32'h8);
    cyc();
    bus.i_wvalid = 4'h0; bus.i_wlast = 4'h0;
    #1;
    chk("t4_ninth_valid", 32'(bus.o_awvalid), 32'h1);
    chk("t4_ninth_ready", 32'(bus.i_awready), 32'h8);
    cyc();
    bus.i_awvalid = 4'h0;

    // Test 6: drain to three entries, hold a BUSY grant, then reset.
    bus.i_wvalid = 4'hF; bus.i_wlast = 4'hF;
    repeat (5) cyc();
    bus.i_wvalid = 4'h0; bus.i_wlast = 4'h0;
    #1;
    chk("t6_head_m1", 32'(bus.i_wready), 32'h2);
    bus.i_awvalid = 4'b0010; bus.o_awready = 1'b0;
    cyc();
    #1;
    chk("t6_busy", 32'(bus.o_awvalid), 32'h1);
    srst = 1'b1;
    cyc();
    #1;
    chk("t6_rst_awvalid", 32'(bus.o_awvalid), 32'h0);
    chk("t6_rst_wready",  32'(bus.i_wready),  32'h0);
    chk("t6_rst_awready", 32'(bus.i_awready), 32'h0);
    srst = 1'b0;
    bus.i_awvalid = 4'hF; bus.o_awready = 1'b1; bus.i_wvalid = 4'hF; bus.i_wlast = 4'hF;
    #1;
    chk("t6_rel_awvalid", 32'(bus.o_awvalid), 32'h0);
    chk("t6_rel_wvalid",  32'(bus.o_wvalid),  32'h0);
    cyc();
    #1;
    chk("t6_restart_m0", 32'(bus.i_awready), 32'h1);
    chk("t6_restart_ch", 32'(bus.o_awch),    32'hA0);
    chk("t6_fifo_empty", 32'(bus.i_wready),  32'h0);
    cyc();
    bus.i_awvalid = 4'h0;
    #1;
    chk("t6_new_head", 32'(bus.i_wready), 32'h1);
    bus.i_wvalid = 4'h0; bus.i_wlast = 4'h0; bus.o_wready = 1'b0;

    // Test 5: B routing by ID.
    bus.o_bvalid = 1'b1; bus.o_bch = 10'h025; bus.i_bready = 4'b0100;
    #1;
    chk("t5_id25_bvalid", 32'(bus.i_bvalid), 32'h4);
    chk("t5_id25_bready", 32'(bus.o_bready), 32'h1);
    chk("t5_id25_bch",    32'(bus.i_bch),    32'h025);
    bus.i_bready = 4'b1011;
    #1;
    chk("t5_id25_stall", 32'(bus.o_bready), 32'h0);
    bus.o_bch = 10'h30F; bus.i_bready = 4'b0001;
    #1;
    chk("t5_id0f_bvalid", 32'(bus.i_bvalid), 32'h1);
    chk("t5_id0f_bready", 32'(bus.o_bready), 32'h1);
    bus.o_bch = 10'h03A;
    #1;
    chk("t5_id3a_bvalid", 32'(bus.i_bvalid), 32'h8);
    bus.o_bvalid = 1'b0;
    #1;
    chk("t5_novalid", 32'(bus.i_bvalid), 32'h0);
    bus1.o_bvalid = 1'b1; bus1.o_bch = 10'h025; bus1.i_bready = 4'hF;
    #1;
    chk("t5_m1cfg_drop_bvalid", 32'(bus1.i_bvalid), 32'h0);
    chk("t5_m1cfg_drop_bready", 32'(bus1.o_bready), 32'h1);
    bus1.o_bch = 10'h015; bus1.i_bready = 4'b1101;
    #1;
    chk("t5_m1cfg_hit_bvalid", 32'(bus1.i_bvalid), 32'h2);
    chk("t5_m1cfg_hit_bready", 32'(bus1.o_bready), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
